// File: rtl/irq_ctrl.sv
// Wishbone interrupt controller: N sources with level/edge mode, mask, W1C pending,
// software set and a lowest-index-first vector register. rdt/ack are zero when idle.
module irq_ctrl #(
  parameter int              ADDR_W = 8,
  parameter logic [ADDR_W-1:0] ADDR = 8'h80,
  parameter int              N      = 8,
  parameter bit              SYNC   = 1'b1
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [31:0]   wb_dbus_adr,
  input  logic [31:0]   wb_dbus_dat,
  input  logic          wb_dbus_we,
  input  logic          wb_dbus_cyc,
  output logic          ack,
  output logic [31:0]   rdt,
  input  logic [N-1:0]  irq_in,
  output logic          irq
);

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_ENABLE  = 3'd2;
  localparam logic [2:0] REG_MODE    = 3'd3;
  localparam logic [2:0] REG_ACTIVE  = 3'd4;
  localparam logic [2:0] REG_VECTOR  = 3'd5;
  localparam logic [2:0] REG_SET     = 3'd6;

  logic [N-1:0] s;
  logic [N-1:0] s_prev;
  logic [N-1:0] lat;
  logic [N-1:0] lat_next;
  logic [N-1:0] enable;
  logic [N-1:0] mode;
  logic [N-1:0] pend;
  logic [N-1:0] active;
  logic [N-1:0] wdat;
  logic [N-1:0] set_hw;
  logic [N-1:0] set_sw;
  logic [N-1:0] clr;
  logic [N-1:0] mode_drop;
  logic [4:0]   vec_idx;
  logic [31:0]  rd;
  logic [2:0]   rsel;
  logic         dev_sel;
  logic         req;
  logic         wr;
  logic         unused_bits;

  generate
    if (SYNC) begin : g_sync
      logic [N-1:0] meta;
      logic [N-1:0] stab;
      always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
          meta <= '0;
          stab <= '0;
        end else begin
          meta <= irq_in;
          stab <= meta;
        end
      end
      assign s = stab;
    end else begin : g_direct
      assign s = irq_in;
    end
  endgenerate

  assign dev_sel = (wb_dbus_adr[31:32-ADDR_W] == ADDR);
  // ~ack keeps a held cyc from producing a second ack right after the first
  assign req  = wb_dbus_cyc & dev_sel & ~ack;
  assign wr   = req & wb_dbus_we;
  assign rsel = wb_dbus_adr[4:2];
  assign wdat = wb_dbus_dat[N-1:0];

  assign unused_bits = ^{wb_dbus_adr, wb_dbus_dat};

  assign pend   = (mode & lat) | (~mode & s);
  assign active = pend & enable;

  // Set sources win over W1C; dropping a bit to level mode clears its latch
  assign set_hw    = s & ~s_prev & mode;
  assign set_sw    = (wr && rsel == REG_SET)     ? (wdat & mode)  : '0;
  assign clr       = (wr && rsel == REG_PENDING) ? wdat           : '0;
  assign mode_drop = (wr && rsel == REG_MODE)    ? (mode & ~wdat) : '0;
  assign lat_next  = ((lat & ~clr) | set_hw | set_sw) & ~mode_drop;

  always_comb begin
    vec_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 5'(i);
    end
  end

  always_comb begin
    rd = '0;
    case (rsel)
      REG_STATUS:  rd[N-1:0] = s;
      REG_PENDING: rd[N-1:0] = pend;
      REG_ENABLE:  rd[N-1:0] = enable;
      REG_MODE:    rd[N-1:0] = mode;
      REG_ACTIVE:  rd[N-1:0] = active;
      REG_VECTOR: begin
        rd[31]  = |active;
        rd[4:0] = vec_idx;
      end
      default:     rd = '0;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack    <= 1'b0;
      rdt    <= '0;
      irq    <= 1'b0;
      s_prev <= '0;
      lat    <= '0;
      enable <= '0;
      mode   <= '0;
    end else begin
      ack    <= req;
      rdt    <= req ? rd : '0;
      irq    <= |active;
      s_prev <= s;
      lat    <= lat_next;
      if (wr && rsel == REG_ENABLE) enable <= wdat;
      if (wr && rsel == REG_MODE)   mode   <= wdat;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: two instances (N=8/SYNC=1 at 0x80, N=32/SYNC=0 at 0x90) on a shared bus.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        ack0, ack1, irq0, irq1;
  logic [31:0] rdt0, rdt1;
  logic [7:0]  irq_in0 = '0;
  logic [31:0] irq_in1 = '0;

  int n_checks = 0;
  int n_errors = 0;

  string       qn0[$];
  logic [31:0] qe0[$];
  bit          qc0[$];
  string       qn1[$];
  logic [31:0] qe1[$];
  bit          qc1[$];
  logic        pack0 = 1'b0;
  logic        pack1 = 1'b0;
  string       en;
  logic [31:0] ee;
  bit          ec;

  always #5 clk = ~clk;

  irq_ctrl #(.ADDR_W(8), .ADDR(8'h80), .N(8), .SYNC(1'b1)) dut0 (
    .wb_clk(clk), .wb_rst_n(rst_n), .wb_dbus_adr(adr), .wb_dbus_dat(dat),
    .wb_dbus_we(we), .wb_dbus_cyc(cyc), .ack(ack0), .rdt(rdt0),
    .irq_in(irq_in0), .irq(irq0)
  );

  irq_ctrl #(.ADDR_W(8), .ADDR(8'h90), .N(32), .SYNC(1'b0)) dut1 (
    .wb_clk(clk), .wb_rst_n(rst_n), .wb_dbus_adr(adr), .wb_dbus_dat(dat),
    .wb_dbus_we(we), .wb_dbus_cyc(cyc), .ack(ack1), .rdt(rdt1),
    .irq_in(irq_in1), .irq(irq1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack pops one expected entry; rdt must be 0 whenever ack is low
  always @(negedge clk) begin
    if (ack0) begin
      check("ack0_single_cycle", {31'b0, pack0}, 32'd0);
      if (qn0.size() == 0) check("ack0_unexpected", 32'd1, 32'd0);
      else begin
        en = qn0.pop_front(); ee = qe0.pop_front(); ec = qc0.pop_front();
        if (ec) check(en, rdt0, ee);
      end
    end else check("rdt0_idle", rdt0, 32'd0);
    if (ack1) begin
      check("ack1_single_cycle", {31'b0, pack1}, 32'd0);
      if (qn1.size() == 0) check("ack1_unexpected", 32'd1, 32'd0);
      else begin
        en = qn1.pop_front(); ee = qe1.pop_front(); ec = qc1.pop_front();
        if (ec) check(en, rdt1, ee);
      end
    end else check("rdt1_idle", rdt1, 32'd0);
    pack0 = ack0;
    pack1 = ack1;
  end

  // Called just after a rising edge; returns just after the edge that shows ack
  task automatic bus(input int which, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input bit chk, input string name);
    bit got;
    if (which == 0) begin qn0.push_back(name); qe0.push_back(exp); qc0.push_back(chk); end
    else begin qn1.push_back(name); qe1.push_back(exp); qc1.push_back(chk); end
    adr = a; dat = d; we = w; cyc = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if ((which == 0) ? ack0 : ack1) got = 1'b1;
    end
    cyc = 1'b0; we = 1'b0;
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] a0(input int r);
    return 32'h8000_0000 | (32'(r) << 2);
  endfunction

  function automatic logic [31:0] a1(input int r);
    return 32'h9000_0000 | (32'(r) << 2);
  endfunction

  task automatic rd0(input int r, input logic [31:0] exp, input string name);
    bus(0, 1'b0, a0(r), 32'd0, exp, 1'b1, name);
  endtask

  task automatic wr0(input int r, input logic [31:0] d);
    bus(0, 1'b1, a0(r), d, 32'd0, 1'b0, "wr0");
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack0", ack0, 0);
    check("rst_irq0", irq0, 0);
    check("rst_irq1", irq1, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a read aborts the ack
    adr = a0(2); we = 1'b0; cyc = 1'b1;
    tick();
    check("ack_before_reset", ack0, 1);
    #1 rst_n = 1'b0;
    #1 check("reset_kills_ack", ack0, 0);
    check("reset_kills_rdt", rdt0, 0);
    cyc = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("no_ack_after_abort", ack0, 0);

    rd0(2, 32'h0, "rst_enable");
    rd0(3, 32'h0, "rst_mode");
    rd0(1, 32'h0, "rst_pending");
    rd0(5, 32'h0, "rst_vector");
    bus(1, 1'b0, a1(2), 0, 32'h0, 1'b1, "rst_enable_n32");
    bus(1, 1'b0, a1(5), 0, 32'h0, 1'b1, "rst_vector_n32");

    wr0(2, 32'hFFFF_FFFF);
    rd0(2, 32'h0000_00FF, "enable_upper_bits");

    // Level mode, two-cycle synchroniser latency
    wr0(2, 32'h04);
    irq_in0[2] = 1'b1;
    tick(); check("lvl_rise_k", irq0, 0);
    tick(); check("lvl_rise_k1", irq0, 0);
    tick(); check("lvl_rise_k2", irq0, 1);
    rd0(5, 32'h8000_0002, "lvl_vector");
    rd0(4, 32'h04, "lvl_active");
    rd0(0, 32'h04, "lvl_status");
    wr0(1, 32'h04);
    rd0(1, 32'h04, "lvl_w1c_ignored");
    check("lvl_irq_after_w1c", irq0, 1);
    irq_in0[2] = 1'b0;
    tick(); check("lvl_fall_k", irq0, 1);
    tick(); check("lvl_fall_k1", irq0, 1);
    tick(); check("lvl_fall_k2", irq0, 0);

    // Edge latch from a one-cycle pulse
    wr0(3, 32'h01);
    wr0(2, 32'h01);
    irq_in0[0] = 1'b1;
    tick(); irq_in0[0] = 1'b0;
    check("edge_k", irq0, 0);
    tick(); check("edge_k1", irq0, 0);
    tick(); check("edge_k2", irq0, 0);
    tick(); check("edge_k3", irq0, 1);
    repeat (4) tick();
    check("edge_holds", irq0, 1);
    rd0(1, 32'h01, "edge_pending");
    wr0(1, 32'h01);
    check("w1c_at_e", irq0, 1);
    tick(); check("w1c_e1", irq0, 0);

    // Priority and masking
    wr0(3, 32'h29);
    wr0(2, 32'h28);
    irq_in0[5] = 1'b1; irq_in0[3] = 1'b1;
    repeat (2) tick();
    irq_in0[5] = 1'b0; irq_in0[3] = 1'b0;
    repeat (4) tick();
    rd0(5, 32'h8000_0003, "prio_vector_3");
    wr0(2, 32'h20);
    rd0(5, 32'h8000_0005, "prio_vector_5");
    wr0(2, 32'h00);
    check("enable_at_e", irq0, 1);
    tick(); check("enable_e1", irq0, 0);
    rd0(5, 32'h0, "masked_vector");
    rd0(1, 32'h28, "masked_pending");
    wr0(1, 32'h28);
    rd0(1, 32'h0, "pending_cleared");

    // Hardware edge beats a simultaneous W1C
    wr0(3, 32'h2B);
    wr0(2, 32'h02);
    wr0(6, 32'h02);
    rd0(1, 32'h02, "sw_set");
    rd0(6, 32'h0, "set_reads_zero");
    irq_in0[1] = 1'b1;
    tick();
    tick();
    wr0(1, 32'h02);
    rd0(1, 32'h02, "set_beats_clr");
    wr0(1, 32'h02);
    rd0(1, 32'h0, "edge_latched_once");

    // Mode changes
    wr0(3, 32'h29);
    rd0(1, 32'h02, "level_follows_input");
    wr0(3, 32'h2B);
    repeat (3) tick();
    rd0(1, 32'h0, "no_edge_on_mode_change");
    irq_in0[1] = 1'b0;
    repeat (3) tick();
    wr0(6, 32'h02);
    rd0(1, 32'h02, "sw_set_again");
    wr0(3, 32'h29);
    rd0(1, 32'h0, "mode_drop_clears_lat");
    wr0(6, 32'h02);
    rd0(1, 32'h0, "set_level_ignored");
    wr0(3, 32'h2B);
    rd0(1, 32'h0, "set_level_not_latched");

    rd0(7, 32'h0, "reserved_reads_zero");
    wr0(7, 32'hFFFF_FFFF);
    rd0(2, 32'h02, "reserved_write_ignored");

    // Nobody selected
    adr = 32'hA000_0000; we = 1'b0; cyc = 1'b1;
    repeat (4) begin
      tick();
      check("unsel_ack0", ack0, 0);
      check("unsel_ack1", ack1, 0);
    end
    cyc = 1'b0;
    tick();

    // N=32, no synchroniser, device at 0x90
    bus(1, 1'b1, a1(2), 32'h8000_0000, 32'h0, 1'b0, "wr1");
    bus(1, 1'b0, a1(2), 0, 32'h8000_0000, 1'b1, "n32_enable");
    irq_in1[31] = 1'b1;
    check("n32_before_k", irq1, 0);
    tick(); check("n32_at_k", irq1, 1);
    bus(1, 1'b0, a1(5), 0, 32'h8000_001F, 1'b1, "n32_vector");
    bus(1, 1'b0, a1(0), 0, 32'h8000_0000, 1'b1, "n32_status");
    // 0x8000_0000 belongs to the other instance only; dut1 must stay silent
    bus(0, 1'b0, 32'h8000_0000, 0, 32'h0, 1'b1, "other_dev_status");
    check("n32_no_ack_other", ack1, 0);
    check("n32_rdt_other", rdt1, 0);
    irq_in1[31] = 1'b0;
    tick(); check("n32_fall_k", irq1, 0);

    repeat (4) tick();
    check("q0_drained", qn0.size(), 0);
    check("q1_drained", qn1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
